// File: rtl/restoring_divider_32_bit.sv
// Sequential 32-bit unsigned restoring divider; one quotient bit per clock using an
// external binary_subtractor_32_bit for the trial subtraction.
module restoring_divider_32_bit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic [WIDTH-1:0] sub_a,
    output logic [WIDTH-1:0] sub_b,
    output logic             sub_cin,
    input  logic [WIDTH-1:0] sub_s,
    input  logic             sub_cout
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   partial;
    logic               qbit;

    assign partial = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    // A set R[31] means the shifted remainder overflowed 32 bits, so it must exceed D.
    assign qbit    = sub_cout | rem_q[WIDTH-1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        sub_a       = '0;
        sub_b       = '0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    dvs_d = divisor;
                    quo_d = dividend;
                    rem_d = '0;
                    cnt_d = '0;
                    if (divisor == '0) begin
                        state_d     = StDone;
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                sub_a = partial;
                sub_b = dvs_q;
                rem_d = qbit ? sub_s : partial;
                quo_d = {quo_q[WIDTH-2:0], qbit};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d     = StDone;
                    quotient_d  = quo_d;
                    remainder_d = rem_d;
                    dbz_d       = 1'b0;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q == StCalc);
    assign done        = (state_q == StDone);
    assign div_by_zero = dbz_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign sub_cin     = 1'b1;

endmodule

// File: tb/tb_restoring_divider_32_bit.sv
// Self-checking bench for restoring_divider_32_bit with a behavioural subtractor model.
module tb_restoring_divider_32_bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic [31:0] sub_a;
    logic [31:0] sub_b;
    logic        sub_cin;
    logic [31:0] sub_s;
    logic        sub_cout;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // a + ~b + cin: carry-out of 1 means no borrow
    assign {sub_cout, sub_s} = {1'b0, sub_a} + {1'b0, ~sub_b} + {32'd0, sub_cin};

    restoring_divider_32_bit dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .quotient   (quotient),
        .remainder  (remainder),
        .sub_a      (sub_a),
        .sub_b      (sub_b),
        .sub_cin    (sub_cin),
        .sub_s      (sub_s),
        .sub_cout   (sub_cout)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Returns at the negedge of the done cycle (or after the cycle budget).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat,
                          output int busy_cycles, output logic timed_out);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        lat         = 1;
        busy_cycles = 0;
        timed_out   = 1'b1;
        #1 start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            @(posedge clk);
            lat++;
        end
    endtask

    initial begin
        int          lat;
        int          bcyc;
        logic        tmo;
        int          t1;
        int          ndone;
        logic [31:0] q1;
        logic [31:0] r1;

        vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        vecs[1]  = '{32'd1234,       32'd0,          32'hFFFFFFFF,   32'd1234,       1'b1};
        vecs[2]  = '{32'hFFFFFFFF,   32'h80000001,   32'd1,          32'h7FFFFFFE,   1'b0};
        vecs[3]  = '{32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
        vecs[4]  = '{32'hFFFFFFFE,   32'hFFFFFFFF,   32'd0,          32'hFFFFFFFE,   1'b0};
        vecs[5]  = '{32'd50,         32'd5,          32'd10,         32'd0,          1'b0};
        vecs[6]  = '{32'd9,          32'd4,          32'd2,          32'd1,          1'b0};
        vecs[7]  = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
        vecs[8]  = '{32'd12345678,   32'd1000,       32'd12345,      32'd678,        1'b0};
        vecs[9]  = '{32'h80000000,   32'd3,          32'h2AAAAAAA,   32'd2,          1'b0};
        vecs[10] = '{32'd0,          32'd0,          32'hFFFFFFFF,   32'd0,          1'b1};

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        check("rst_sub_a", sub_a, 32'd0);
        check("rst_sub_b", sub_b, 32'd0);
        check("rst_sub_cin", {31'd0, sub_cin}, 32'd1);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].a, vecs[i].b, lat, bcyc, tmo);
            check($sformatf("v%0d_timeout", i), {31'd0, tmo}, 32'd0);
            check($sformatf("v%0d_quotient", i), quotient, vecs[i].q);
            check($sformatf("v%0d_remainder", i), remainder, vecs[i].r);
            check($sformatf("v%0d_dbz", i), {31'd0, div_by_zero}, {31'd0, vecs[i].dbz});
            check($sformatf("v%0d_latency", i), 32'(lat), vecs[i].dbz ? 32'd1 : 32'd33);
            check($sformatf("v%0d_busy_cycles", i), 32'(bcyc), vecs[i].dbz ? 32'd0 : 32'd32);
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
            check($sformatf("v%0d_idle_sub_a", i), sub_a, 32'd0);
            check($sformatf("v%0d_hold_quotient", i), quotient, vecs[i].q);
        end

        // start held through CALC while operands change: only first sample counts
        @(negedge clk);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        lat      = 0;
        tmo      = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done) begin
                start = 1'b0;
                tmo   = 1'b0;
                break;
            end
            dividend = $urandom;
            divisor  = $urandom | 32'd1;
        end
        check("hold_timeout", {31'd0, tmo}, 32'd0);
        check("hold_latency", 32'(lat), 32'd33);
        check("hold_quotient", quotient, 32'd14);
        check("hold_remainder", remainder, 32'd2);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("hold_single_done", 32'(ndone), 32'd0);

        // back-to-back: start kept high, operands switched during the done cycle
        @(negedge clk);
        dividend = 32'd50;
        divisor  = 32'd5;
        start    = 1'b1;
        ndone    = 0;
        t1       = 0;
        q1       = '0;
        r1       = '0;
        lat      = 0;
        for (int i = 0; i < 120; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    t1       = lat;
                    q1       = quotient;
                    r1       = remainder;
                    dividend = 32'd9;
                    divisor  = 32'd4;
                end else begin
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        check("b2b_done_count", 32'(ndone), 32'd2);
        check("b2b_q1", q1, 32'd10);
        check("b2b_r1", r1, 32'd0);
        check("b2b_q2", quotient, 32'd2);
        check("b2b_r2", remainder, 32'd1);
        check("b2b_spacing", 32'(lat - t1), 32'd34);

        // reset during CALC discards the operation
        @(negedge clk);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("mid_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_busy", {31'd0, busy}, 32'd0);
        check("mid_done", {31'd0, done}, 32'd0);
        check("mid_quotient", quotient, 32'd0);
        check("mid_remainder", remainder, 32'd0);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("mid_no_done", 32'(ndone), 32'd0);
        run_op(32'd81, 32'd9, lat, bcyc, tmo);
        check("post_rst_timeout", {31'd0, tmo}, 32'd0);
        check("post_rst_quotient", quotient, 32'd9);
        check("post_rst_remainder", remainder, 32'd0);
        check("post_rst_latency", 32'(lat), 32'd33);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
